// File: rtl/key_pkg.sv
// Shared encodings and the click-to-mode stepping rule for the key click decoder.
package key_pkg;
   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_WAIT = 2'd1;
   localparam logic [1:0] ST_EMIT = 2'd2;

   localparam logic [1:0] CLK_SINGLE = 2'd1;
   localparam logic [1:0] CLK_DOUBLE = 2'd2;
   localparam logic [1:0] CLK_TRIPLE = 2'd3;

   localparam logic [23:0] WIN_300MS = 24'd14_999_999;

   // single steps the mode up, double steps it down, triple clears it
   function automatic logic [1:0] next_mode(input logic [1:0] mode, input logic [1:0] clicks);
      case (clicks)
         CLK_SINGLE: next_mode = mode + 2'd1;
         CLK_DOUBLE: next_mode = mode - 2'd1;
         CLK_TRIPLE: next_mode = 2'd0;
         default:    next_mode = mode;
      endcase
   endfunction
endpackage

// File: rtl/key_click_decoder_if.sv
// Press input and click event outputs of the key click decoder.
interface key_click_decoder_if;
   logic       key_flag;
   logic       click_valid;
   logic [1:0] click_num;
   logic [1:0] led_mode;
   logic       busy;

   modport master (output key_flag, input click_valid, click_num, led_mode, busy);
   modport slave  (input key_flag, output click_valid, click_num, led_mode, busy);
endinterface

// File: rtl/key_click_decoder_click_win_timer.sv
// Click window counter: counts up while enabled, expire flags the last window cycle.
module click_win_timer
   import key_pkg::*;
#(
   parameter logic [23:0] CNT_WIN = WIN_300MS
) (
   input  logic sys_clk,
   input  logic sys_rst,
   input  logic clr,
   input  logic en,
   output logic expire
);
   localparam logic [23:0] CNT_LAST = CNT_WIN - 24'd1;

   logic [23:0] win_cnt;

   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst)
         win_cnt <= 24'd0;
      else if (clr)
         win_cnt <= 24'd0;
      else if (en)
         win_cnt <= win_cnt + 24'd1;
   end

   assign expire = en && (win_cnt == CNT_LAST);
endmodule

// File: rtl/key_click_decoder.sv
// Groups debounced presses into single/double/triple click events and steps a 2-bit mode.
//   state   | meaning
//   ST_IDLE | no sequence open
//   ST_WAIT | presses counted, window running
//   ST_EMIT | one-cycle click event, led_mode updates at its end
module key_click_decoder
   import key_pkg::*;
#(
   parameter logic [23:0] CNT_WIN    = WIN_300MS,
   parameter logic [1:0]  MAX_CLICKS = 2'd3
) (
   input  logic                sys_clk,
   input  logic                sys_rst,
   key_click_decoder_if.slave  bus
);
   logic [1:0] state, state_nxt;
   logic [1:0] clicks, clicks_nxt;
   logic [1:0] led_mode, click_num;
   logic       click_valid, busy;
   logic       win_clr, win_en, win_expire;

   // window restarts on every press and whenever a sequence is not waiting
   assign win_en  = (state == ST_WAIT);
   assign win_clr = !win_en || bus.key_flag || win_expire;

   click_win_timer #(.CNT_WIN(CNT_WIN)) u_timer (
      .sys_clk (sys_clk),
      .sys_rst (sys_rst),
      .clr     (win_clr),
      .en      (win_en),
      .expire  (win_expire)
   );

   always_comb begin
      state_nxt  = state;
      clicks_nxt = clicks;
      case (state)
         ST_IDLE: begin
            if (bus.key_flag) begin
               state_nxt  = ST_WAIT;
               clicks_nxt = 2'd1;
            end
         end
         ST_WAIT: begin
            // a press on the expiry cycle still counts
            if (bus.key_flag) begin
               clicks_nxt = clicks + 2'd1;
               if (clicks + 2'd1 == MAX_CLICKS)
                  state_nxt = ST_EMIT;
            end else if (win_expire) begin
               state_nxt = ST_EMIT;
            end
         end
         ST_EMIT: begin
            if (bus.key_flag) begin
               state_nxt  = ST_WAIT;
               clicks_nxt = 2'd1;
            end else begin
               state_nxt  = ST_IDLE;
               clicks_nxt = 2'd0;
            end
         end
         default: begin
            state_nxt  = ST_IDLE;
            clicks_nxt = 2'd0;
         end
      endcase
   end

   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         state       <= ST_IDLE;
         clicks      <= 2'd0;
         click_valid <= 1'b0;
         click_num   <= 2'd0;
         led_mode    <= 2'd0;
         busy        <= 1'b0;
      end else begin
         state       <= state_nxt;
         clicks      <= clicks_nxt;
         busy        <= (state_nxt != ST_IDLE);
         click_valid <= (state_nxt == ST_EMIT);
         click_num   <= (state_nxt == ST_EMIT) ? clicks_nxt : 2'd0;
         if (state == ST_EMIT)
            led_mode <= next_mode(led_mode, clicks);
      end
   end

   assign bus.click_valid = click_valid;
   assign bus.click_num   = click_num;
   assign bus.led_mode    = led_mode;
   assign bus.busy        = busy;
endmodule

// File: tb/tb_key_click_decoder.sv
// Table-driven click sequences with an event scoreboard, plus an async reset corner case.
module tb_key_click_decoder;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   edge_n = 0;
   int   checks = 0;
   int   errors = 0;

   key_click_decoder_if bus ();

   key_click_decoder #(.CNT_WIN(24'd20), .MAX_CLICKS(2'd3)) dut (
      .sys_clk (clk),
      .sys_rst (rst),
      .bus     (bus.slave)
   );

   always #10 clk = ~clk;
   always @(posedge clk) edge_n <= edge_n + 1;

   typedef struct {
      string      name;
      int         n_press;
      int         gap;
      int         n_ev;
      int         at0;
      logic [1:0] num0;
      logic [1:0] led0;
      logic       busy0;
      int         at1;
      logic [1:0] num1;
      logic [1:0] led1;
      logic       busy1;
   } vec_t;

   typedef struct {
      string      name;
      int         at;
      logic [1:0] num;
      logic [1:0] led_before;
      logic [1:0] led_after;
      logic       busy_after;
   } ev_t;

   ev_t        exp_q[$];
   vec_t       vecs[8];
   logic [1:0] last_led = 2'd0;
   logic       prev_valid = 1'b0;
   logic       pend = 1'b0;
   ev_t        pend_ev;
   int         events_seen = 0;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, exp, edge_n);
      end
   endtask

   task automatic push_ev(input string name, input int at, input logic [1:0] num,
                          input logic [1:0] led, input logic busy_after);
      ev_t e;
      e.name = name; e.at = at; e.num = num;
      e.led_before = last_led; e.led_after = led; e.busy_after = busy_after;
      last_led = led;
      exp_q.push_back(e);
   endtask

   // called once per cycle right after the falling edge
   task automatic monitor_cycle();
      ev_t e;
      if (pend) begin
         chk({pend_ev.name, " led_after"}, int'(bus.led_mode), int'(pend_ev.led_after));
         chk({pend_ev.name, " busy_after"}, int'(bus.busy), int'(pend_ev.busy_after));
         pend = 1'b0;
      end
      if (bus.click_valid) begin
         events_seen++;
         if (prev_valid) chk("valid_back_to_back", 1, 0);
         if (exp_q.size() == 0) begin
            chk("unexpected_event", 1, 0);
         end else begin
            e = exp_q.pop_front();
            chk({e.name, " event_edge"}, edge_n, e.at);
            chk({e.name, " click_num"}, int'(bus.click_num), int'(e.num));
            chk({e.name, " led_before"}, int'(bus.led_mode), int'(e.led_before));
            chk({e.name, " busy_in_emit"}, int'(bus.busy), 1);
            pend_ev = e;
            pend = 1'b1;
         end
      end else if (bus.click_num != 2'd0) begin
         chk("click_num_idle", int'(bus.click_num), 0);
      end
      prev_valid = bus.click_valid;
   endtask

   task automatic drive_row(input vec_t v);
      int start, last_press;
      start = edge_n + 1;
      last_press = (v.n_press - 1) * v.gap;
      push_ev(v.name, start + v.at0, v.num0, v.led0, v.busy0);
      if (v.n_ev > 1) push_ev(v.name, start + v.at1, v.num1, v.led1, v.busy1);
      for (int c = 0; c <= last_press + 45; c++) begin
         bus.key_flag = (c == 0) || (v.gap != 0 && c % v.gap == 0 && c / v.gap < v.n_press);
         @(negedge clk);
         monitor_cycle();
      end
      bus.key_flag = 1'b0;
      chk({v.name, " events_pending"}, exp_q.size(), 0);
      exp_q.delete();
      chk({v.name, " busy_end"}, int'(bus.busy), 0);
   endtask

   initial begin
      vec_t single_row;
      int   seen_before;

      vecs[0] = '{"single",        1, 0,  1, 20, 2'd1, 2'd1, 1'b0, 0,  2'd0, 2'd0, 1'b0};
      vecs[1] = '{"double",        2, 10, 1, 30, 2'd2, 2'd0, 1'b0, 0,  2'd0, 2'd0, 1'b0};
      vecs[2] = '{"double_wrap",   2, 10, 1, 30, 2'd2, 2'd3, 1'b0, 0,  2'd0, 2'd0, 1'b0};
      vecs[3] = '{"triple",        3, 5,  1, 10, 2'd3, 2'd0, 1'b0, 0,  2'd0, 2'd0, 1'b0};
      vecs[4] = '{"press_expiry",  2, 20, 1, 40, 2'd2, 2'd3, 1'b0, 0,  2'd0, 2'd0, 1'b0};
      vecs[5] = '{"press_in_emit", 2, 21, 2, 20, 2'd1, 2'd0, 1'b1, 41, 2'd1, 2'd1, 1'b0};
      vecs[6] = '{"double_late",   2, 19, 1, 39, 2'd2, 2'd0, 1'b0, 0,  2'd0, 2'd0, 1'b0};
      vecs[7] = '{"triple_late",   3, 19, 1, 38, 2'd3, 2'd0, 1'b0, 0,  2'd0, 2'd0, 1'b0};
      single_row = '{"single_again", 1, 0, 1, 20, 2'd1, 2'd1, 1'b0, 0, 2'd0, 2'd0, 1'b0};

      bus.key_flag = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk("reset click_valid", int'(bus.click_valid), 0);
      chk("reset click_num", int'(bus.click_num), 0);
      chk("reset led_mode", int'(bus.led_mode), 0);
      chk("reset busy", int'(bus.busy), 0);
      rst = 1'b0;
      @(negedge clk);

      for (int i = 0; i < 8; i++) drive_row(vecs[i]);

      // leave led_mode at 1, then open a double-click sequence and kill it with reset
      drive_row(single_row);
      for (int c = 0; c < 9; c++) begin
         bus.key_flag = (c == 0) || (c == 5);
         @(negedge clk);
         monitor_cycle();
      end
      bus.key_flag = 1'b0;
      chk("pre_reset busy", int'(bus.busy), 1);
      chk("pre_reset led_mode", int'(bus.led_mode), 1);
      @(posedge clk);
      #3 rst = 1'b1;
      #1;
      chk("async_reset click_valid", int'(bus.click_valid), 0);
      chk("async_reset click_num", int'(bus.click_num), 0);
      chk("async_reset led_mode", int'(bus.led_mode), 0);
      chk("async_reset busy", int'(bus.busy), 0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      prev_valid = 1'b0;
      pend = 1'b0;
      seen_before = events_seen;
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         monitor_cycle();
      end
      chk("post_reset no_event", events_seen, seen_before);
      chk("post_reset busy", int'(bus.busy), 0);
      last_led = 2'd0;
      single_row.name = "single_after_reset";
      drive_row(single_row);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
